// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// opcode field width.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle integer operations (ADD..SLTU); every other code, including
// the iterative ones handled by the parent, yields zero.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: base ops in one cycle, unsigned MUL/MULHU/DIVU/REMU over
// XLEN cycles. Define ALU_MUL_EARLY_EXIT_EN to finish multiplies early.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ALU_OP_W-1:0] req_op,
    input  logic [XLEN-1:0]     req_a,
    input  logic [XLEN-1:0]     req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    alu_state_t            state_q;
    logic [ALU_OP_W-1:0]   op_q;
    logic [CNT_W-1:0]      count_q;
    logic [2*XLEN-1:0]     prodAcc_q;
    logic [2*XLEN-1:0]     multiplicand_q;
    logic [XLEN-1:0]       operandB_q;
    logic [XLEN-1:0]       result_q;

    logic                  accept;
    logic                  isMulReq;
    logic                  isDivReq;
    logic                  isMulOp;
    logic [XLEN-1:0]       combResult;
    alu_state_t            startState_d;
    logic [XLEN-1:0]       startResult_d;
    logic [2*XLEN-1:0]     mulAcc_d;
    logic [XLEN-1:0]       multiplier_d;
    logic [XLEN:0]         remShift;
    logic [XLEN:0]         trial;
    logic [2*XLEN-1:0]     divAcc_d;
    logic [2*XLEN-1:0]     stepAcc_d;
    logic                  stepDone;
    logic [XLEN-1:0]       stepResult_d;

    alu_comb #(.XLEN(XLEN)) uComb (
        .op_i     (req_op),
        .a_i      (req_a),
        .b_i      (req_b),
        .result_o (combResult)
    );

    always_comb begin
        case (state_q)
            IDLE:    req_ready = 1'b1;
            DONE:    req_ready = resp_ready;
            default: req_ready = 1'b0;
        endcase
    end

    assign accept      = req_valid && req_ready && !flush;
    assign resp_valid  = (state_q == DONE);
    assign resp_result = result_q;

    assign isMulReq = (req_op == ALU_MUL)  || (req_op == ALU_MULHU);
    assign isDivReq = (req_op == ALU_DIVU) || (req_op == ALU_REMU);
    assign isMulOp  = (op_q == ALU_MUL)    || (op_q == ALU_MULHU);

    // Divide by zero never iterates; its architectural result is fixed.
    always_comb begin
        startState_d  = DONE;
        startResult_d = combResult;
        if (isDivReq) begin
            if (req_b == '0) begin
                startResult_d = (req_op == ALU_DIVU) ? '1 : req_a;
            end else begin
                startState_d = BUSY;
            end
        end else if (isMulReq) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (req_b != '0) begin
                startState_d = BUSY;
            end
`else
            startState_d = BUSY;
`endif
        end
    end

    // Multiply keeps the product aligned in place: the multiplicand moves
    // left while the multiplier drains right, so an early stop is exact.
    assign mulAcc_d     = prodAcc_q + (operandB_q[0] ? multiplicand_q : '0);
    assign multiplier_d = operandB_q >> 1;

    // Divide reuses the accumulator as {remainder, dividend/quotient}.
    assign remShift = prodAcc_q[2*XLEN-1:XLEN-1];
    assign trial    = remShift - {1'b0, operandB_q};
    assign divAcc_d = trial[XLEN]
                    ? {remShift[XLEN-1:0], prodAcc_q[XLEN-2:0], 1'b0}
                    : {trial[XLEN-1:0],    prodAcc_q[XLEN-2:0], 1'b1};

    assign stepAcc_d = isMulOp ? mulAcc_d : divAcc_d;

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign stepDone = (count_q == CNT_W'(1)) || (isMulOp && (multiplier_d == '0));
`else
    assign stepDone = (count_q == CNT_W'(1));
`endif

    assign stepResult_d = ((op_q == ALU_MUL) || (op_q == ALU_DIVU))
                        ? stepAcc_d[XLEN-1:0]
                        : stepAcc_d[2*XLEN-1:XLEN];

    // Control FSM and iterative datapath; flush outranks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= '0;
            count_q        <= '0;
            prodAcc_q      <= '0;
            multiplicand_q <= '0;
            operandB_q     <= '0;
            result_q       <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            count_q <= '0;
        end else if (accept) begin
            state_q        <= startState_d;
            op_q           <= req_op;
            count_q        <= CNT_W'(XLEN);
            prodAcc_q      <= isDivReq ? {{XLEN{1'b0}}, req_a} : '0;
            multiplicand_q <= {{XLEN{1'b0}}, req_a};
            operandB_q     <= req_b;
            if (startState_d == DONE) begin
                result_q <= startResult_d;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    prodAcc_q      <= stepAcc_d;
                    multiplicand_q <= multiplicand_q << 1;
                    count_q        <= count_q - 1'b1;
                    if (isMulOp) begin
                        operandB_q <= multiplier_d;
                    end
                    if (stepDone) begin
                        state_q  <= DONE;
                        result_q <= stepResult_d;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [3:0]      req_op = '0;
    logic [XLEN-1:0] req_a = '0;
    logic [XLEN-1:0] req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [XLEN-1:0] resp_result;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
        end
    endtask

    // Results straight from the arithmetic definition of each opcode.
    function automatic logic [31:0] refResult(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0]        prod;
        logic signed [31:0] sa;
        logic [4:0]         sh;
        prod = {32'b0, a} * {32'b0, b};
        sa   = a;
        sh   = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return sa >>> sh;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return prod[31:0];
            4'd11:   return prod[63:32];
            4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from the accepting edge until resp_valid is first seen.
    function automatic int refLatency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd10 || op == 4'd11) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (b == 0) return 1;
            for (int i = 31; i >= 0; i--) begin
                if (b[i]) return i + 2;
            end
`endif
            return XLEN + 1;
        end
        if ((op == 4'd12 || op == 4'd13) && b != 0) return XLEN + 1;
        return 1;
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int stall);
        logic [31:0] expRes;
        int          expLat;
        int          lat;
        bit          seen;
        expRes = refResult(op, a, b);
        expLat = refLatency(op, b);
        @(negedge clk);
        checkOutput("idleReady", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = (stall == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom_range(0, 15));
        req_a     = $urandom;
        req_b     = $urandom;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            lat = i;
            if (resp_valid) seen = 1'b1;
            else if (i == 1) checkOutput("busyReady", 64'(req_ready), 64'd0);
        end
        checkOutput($sformatf("respSeen op%0d", op), 64'(seen), 64'd1);
        checkOutput($sformatf("latency op%0d", op), 64'(lat), 64'(expLat));
        checkOutput($sformatf("result op%0d a=%0h b=%0h", op, a, b),
                    64'(resp_result), 64'(expRes));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stallValid", 64'(resp_valid), 64'd1);
            checkOutput("stallResult", 64'(resp_result), 64'(expRes));
            checkOutput("stallReady", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("consumed", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        #12;
        checkOutput("rstValid", 64'(resp_valid), 64'd0);
        checkOutput("rstResult", 64'(resp_result), 64'd0);
        checkOutput("rstReady", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'd0, 32'd7, 32'd5, 0);
        applyStimulus(4'd7, 32'h8000_0000, 32'h21, 0);
        applyStimulus(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(4'd12, 32'd100, 32'd7, 0);
        applyStimulus(4'd13, 32'd100, 32'd7, 0);
        applyStimulus(4'd12, 32'hDEAD_BEEF, 32'd0, 0);
        applyStimulus(4'd13, 32'h1234, 32'd0, 0);
        applyStimulus(4'd10, 32'd3, 32'd5, 0);
        applyStimulus(4'd14, 32'd9, 32'd9, 0);
        applyStimulus(4'd15, 32'd9, 32'd9, 1);

        // Back-pressure, then a back-to-back XOR on the releasing edge.
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = 4'd1;
        req_a      = 32'd3;
        req_b      = 32'd5;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bpValid", 64'(resp_valid), 64'd1);
            checkOutput("bpResult", 64'(resp_result), 64'hFFFF_FFFE);
            checkOutput("bpReady", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = 4'd4;
        req_a      = 32'hF0F0_F0F0;
        req_b      = 32'h0FF0_0FF0;
        #1;
        checkOutput("b2bReady", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2bValid", 64'(resp_valid), 64'd1);
        checkOutput("b2bResult", 64'(resp_result), 64'hFF00_FF00);
        @(negedge clk);
        checkOutput("b2bConsumed", 64'(resp_valid), 64'd0);

        // Flush in the tenth busy cycle of a divide; the ADD offered with it is dropped.
        req_valid = 1'b1;
        req_op    = 4'd12;
        req_a     = 32'd100;
        req_b     = 32'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 32'd1;
        req_b     = 32'd1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("flushValid", 64'(resp_valid), 64'd0);
        checkOutput("flushReady", 64'(req_ready), 64'd1);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        checkOutput("flushNoPulse", 64'(pulses), 64'd0);
        applyStimulus(4'd0, 32'd1, 32'd1, 0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd10;
        req_a     = 32'h0001_2345;
        req_b     = 32'h0000_6789;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncValid", 64'(resp_valid), 64'd0);
        checkOutput("asyncResult", 64'(resp_result), 64'd0);
        checkOutput("asyncReady", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd1, 0);

        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(0, 40);
                2:       ra = $urandom_range(0, 1000);
                default: ;
            endcase
            applyStimulus(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
